param_curam: RTL and testbench
==============================

PARAM_CURAM -- requirements
Module: param_curam

Interface
REQ-001 SHALL have parameter DATA_W, default 25, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 100, number of entries (legal range 2..2**ADDR_W).
REQ-003 SHALL have parameter ADDR_W, default 7, address width in bits.
REQ-004 SHALL have parameter BYPASS, default 1, read-during-write policy (1 = return new data, 0 = return old data).
REQ-005 SHALL have port clk, input, 1, single clock; all logic updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on the rising edge of clk.
REQ-007 SHALL have port wr_en, input, 1, write request.
REQ-008 SHALL have port wr_add, input, ADDR_W, write address.
REQ-009 SHALL have port wr_data, input, DATA_W, write data.
REQ-010 SHALL have port rd_en, input, 1, read request.
REQ-011 SHALL have port read_add, input, ADDR_W, read address.
REQ-012 SHALL have port clr_req, input, 1, request to zero the whole memory.
REQ-013 SHALL have port read_data, output, DATA_W, registered read data.
REQ-014 SHALL have port rd_valid, output, 1, one-cycle pulse marking new read_data.
REQ-015 SHALL have port busy, output, 1, high while a clear sweep runs.
REQ-016 SHALL have port addr_err, output, 1, one-cycle pulse on any out-of-range access.

Function
REQ-017 SHALL implement a two-state FSM, IDLE and CLEAR, with an ADDR_W-bit sweep pointer.
REQ-018 In CLEAR, SHALL write zero to the entry at the pointer each cycle and increment the pointer; on the cycle writing DEPTH-1, SHALL go to IDLE, so busy is high for exactly DEPTH cycles.
REQ-019 In IDLE, clr_req=1 at an edge SHALL set state CLEAR, pointer 0, busy 1; clr_req SHALL be ignored while busy.
REQ-020 While busy=1, user writes and reads SHALL be dropped; rd_valid SHALL stay 0 and read_data SHALL hold its value.
REQ-021 In IDLE, wr_en=1 with wr_add<DEPTH SHALL write wr_data to that entry at the edge.
REQ-022 In IDLE, rd_en=1 with read_add<DEPTH SHALL load read_data from that entry at the edge (1-cycle latency) and pulse rd_valid for that one cycle.
REQ-023 With rd_en=0, or on a dropped read, read_data SHALL hold and rd_valid SHALL be 0.
REQ-024 An address >= DEPTH on an enabled port while in IDLE SHALL drop that access, leave memory unchanged, and pulse addr_err the next cycle; for such a read, read_data SHALL hold and rd_valid SHALL be 0.
REQ-025 If both ports are enabled in IDLE with equal in-range addresses, the write SHALL complete; read_data SHALL equal wr_data if BYPASS=1, else the prior contents, and rd_valid SHALL pulse.
REQ-026 Simultaneous in-range read and write to different addresses SHALL both complete in the same cycle.
REQ-027 clr_req accepted together with wr_en/rd_en in IDLE SHALL let that same-cycle access complete first; the sweep SHALL start on the next cycle.
REQ-028 addr_err SHALL be 0 while busy=1.

Reset
REQ-029 rst_n=0 at an edge SHALL set read_data=0, rd_valid=0, addr_err=0, state=CLEAR, pointer=0, busy=1.
REQ-030 Memory SHALL be zeroed by the sweep after reset; the first sweep write SHALL occur at the first edge with rst_n=1.
REQ-031 Reset asserted mid-sweep SHALL restart the sweep from pointer 0.
REQ-032 Reset SHALL override all other inputs in the same cycle.

Verification
REQ-033 Release reset, count cycles -> busy high exactly 100 cycles; rd_en at addr 99 afterwards -> read_data 0, rd_valid 1.
REQ-034 Write 0x1ABCDEF at addr 5, then read addr 5 -> read_data 0x1ABCDEF one cycle after rd_en, rd_valid a single-cycle pulse.
REQ-035 Same-cycle write 0x0000123 and read at addr 7 (prior 0x0000055) -> BYPASS=1 gives 0x0000123; BYPASS=0 gives 0x0000055; next read gives 0x0000123.
REQ-036 Write addr 100 with 0x1FFFFFF, read addr 127 -> addr_err pulses each time, memory unchanged, rd_valid 0, read_data held.
REQ-037 Fill addrs 0..3, assert clr_req, issue writes and reads during busy -> accesses dropped, busy high 100 cycles, then addrs 0..3 read 0.
REQ-038 Assert rst_n=0 at sweep pointer 50 -> outputs reset; busy high 100 cycles after release.

Source files
------------

// File: rtl/param_curam.sv
// Parameterised clearable single-port-pair RAM: one write port, one registered read port,
// and a sweep engine that zeroes every entry after reset or on request.
module param_curam #(
  parameter int DATA_W = 25,
  parameter int DEPTH  = 100,
  parameter int ADDR_W = 7,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_add,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] read_add,
  input  logic              clr_req,
  output logic [DATA_W-1:0] read_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              addr_err
);

  typedef enum logic {IDLE, CLEAR} state_t;

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH-1);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              addr_err_q, addr_err_d;

  logic              wr_in_range, rd_in_range;
  logic              wr_ok, rd_ok;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  assign wr_in_range = ({1'b0, wr_add}   < DEPTH_C);
  assign rd_in_range = ({1'b0, read_add} < DEPTH_C);
  assign wr_ok       = wr_en && wr_in_range;
  assign rd_ok       = rd_en && rd_in_range;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    read_data_d = read_data_q;
    rd_valid_d  = 1'b0;
    addr_err_d  = 1'b0;
    mem_we      = 1'b0;
    mem_wa      = wr_add;
    mem_wd      = wr_data;
    if (state_q == CLEAR) begin
      mem_we = rst_n;
      mem_wa = ptr_q;
      mem_wd = '0;
      ptr_d  = ptr_q + ADDR_W'(1);
      if (ptr_q == LAST_C) begin
        state_d = IDLE;
      end
    end else begin
      mem_we     = rst_n && wr_ok;
      addr_err_d = (wr_en && !wr_in_range) || (rd_en && !rd_in_range);
      if (rd_ok) begin
        rd_valid_d = 1'b1;
        // A colliding write either forwards its data or lets the old word through.
        if ((BYPASS != 0) && wr_ok && (wr_add == read_add)) begin
          read_data_d = wr_data;
        end else begin
          read_data_d = mem[read_add];
        end
      end
      // The same-cycle access above still completes; the sweep begins next edge.
      if (clr_req) begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      ptr_q       <= '0;
      read_data_q <= '0;
      rd_valid_q  <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      read_data_q <= read_data_d;
      rd_valid_q  <= rd_valid_d;
      addr_err_q  <= addr_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  assign read_data = read_data_q;
  assign rd_valid  = rd_valid_q;
  assign addr_err  = addr_err_q;
  assign busy      = (state_q == CLEAR);

endmodule

// File: tb/tb_param_curam.sv
// Drives a BYPASS=1 and a BYPASS=0 instance with identical stimulus and compares
// both against an array-based reference model of the memory's observable behaviour.
module tb_param_curam;

  localparam int DW = 25;
  localparam int D  = 100;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst_n, wr_en, rd_en, clr_req;
  logic [AW-1:0] wr_add, read_add;
  logic [DW-1:0] wr_data;

  logic [DW-1:0] read_data1, read_data0;
  logic          rd_valid1, rd_valid0, busy1, busy0, addr_err1, addr_err0;

  always #5 clk = ~clk;

  param_curam #(.DATA_W(DW), .DEPTH(D), .ADDR_W(AW), .BYPASS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_add(wr_add), .wr_data(wr_data),
    .rd_en(rd_en), .read_add(read_add), .clr_req(clr_req),
    .read_data(read_data1), .rd_valid(rd_valid1), .busy(busy1), .addr_err(addr_err1)
  );

  param_curam #(.DATA_W(DW), .DEPTH(D), .ADDR_W(AW), .BYPASS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_add(wr_add), .wr_data(wr_data),
    .rd_en(rd_en), .read_add(read_add), .clr_req(clr_req),
    .read_data(read_data0), .rd_valid(rd_valid0), .busy(busy0), .addr_err(addr_err0)
  );

  // Reference model: contents, expected outputs, remaining busy cycles.
  logic [DW-1:0] ref_mem [D];
  logic [DW-1:0] e_rd1, e_rd0;
  logic          e_val, e_err;
  int            busy_left;

  int checks = 0;
  int errors = 0;
  int n_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic idle_in();
    wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
    wr_add = '0; read_add = '0; wr_data = '0;
  endtask

  task automatic zero_ref();
    for (int i = 0; i < D; i++) ref_mem[i] = '0;
  endtask

  // Model one rising edge with the inputs currently applied, then check at the falling edge.
  task automatic cycle();
    bit wr_in, rd_in;
    if (!rst_n) begin
      busy_left = D;
      e_rd1 = '0; e_rd0 = '0; e_val = 1'b0; e_err = 1'b0;
      zero_ref();
    end else if (busy_left > 0) begin
      busy_left--;
      e_val = 1'b0; e_err = 1'b0;
    end else begin
      wr_in = wr_en && (int'(wr_add) < D);
      rd_in = rd_en && (int'(read_add) < D);
      e_err = (wr_en && !wr_in) || (rd_en && !rd_in);
      e_val = rd_in;
      if (rd_in) begin
        e_rd0 = ref_mem[read_add];
        e_rd1 = (wr_in && wr_add == read_add) ? wr_data : ref_mem[read_add];
      end
      if (wr_in) ref_mem[wr_add] = wr_data;
      if (clr_req) begin
        busy_left = D;
        zero_ref();
      end
    end
    @(negedge clk);
    chk("read_data_b1", 32'(read_data1), 32'(e_rd1));
    chk("read_data_b0", 32'(read_data0), 32'(e_rd0));
    chk("rd_valid_b1",  32'(rd_valid1),  32'(e_val));
    chk("rd_valid_b0",  32'(rd_valid0),  32'(e_val));
    chk("busy_b1",      32'(busy1),      32'(busy_left > 0));
    chk("busy_b0",      32'(busy0),      32'(busy_left > 0));
    chk("addr_err_b1",  32'(addr_err1),  32'(e_err));
    chk("addr_err_b0",  32'(addr_err0),  32'(e_err));
  endtask

  // Count falling-edge samples with busy high; optionally hammer the ports meanwhile.
  task automatic count_busy(input bit rnd, output int n);
    n = 0;
    for (int i = 0; i < 3 * D; i++) begin
      if (!busy1) break;
      n++;
      if (rnd) begin
        wr_en    = 1'($urandom_range(0, 1));
        rd_en    = 1'($urandom_range(0, 1));
        clr_req  = 1'($urandom_range(0, 1));
        wr_add   = AW'($urandom_range(0, 127));
        read_add = AW'($urandom_range(0, 127));
        wr_data  = DW'($urandom());
      end
      cycle();
    end
    idle_in();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_in();
    zero_ref();
    busy_left = D;
    e_rd1 = '0; e_rd0 = '0; e_val = 1'b0; e_err = 1'b0;

    // Reset and the initial sweep
    cycle();
    cycle();
    rst_n = 1'b1;
    count_busy(1'b0, n_busy);
    chk("busy_len_reset", 32'(n_busy), 32'(D));

    rd_en = 1'b1; read_add = AW'(99);
    cycle();
    chk("rd99_zero", 32'(read_data1), 32'h0);
    chk("rd99_valid", 32'(rd_valid1), 32'h1);
    idle_in();

    // Plain write then read, single-cycle valid pulse
    wr_en = 1'b1; wr_add = AW'(5); wr_data = 25'h1ABCDEF;
    cycle();
    idle_in(); rd_en = 1'b1; read_add = AW'(5);
    cycle();
    chk("rd5_data", 32'(read_data1), 32'h1ABCDEF);
    chk("rd5_valid", 32'(rd_valid1), 32'h1);
    idle_in();
    cycle();
    chk("rd5_pulse_end", 32'(rd_valid1), 32'h0);
    chk("rd5_hold", 32'(read_data1), 32'h1ABCDEF);

    // Read-during-write collision under both policies
    wr_en = 1'b1; wr_add = AW'(7); wr_data = 25'h0000055;
    cycle();
    wr_data = 25'h0000123; rd_en = 1'b1; read_add = AW'(7);
    cycle();
    chk("rdw_bypass1", 32'(read_data1), 32'h123);
    chk("rdw_bypass0", 32'(read_data0), 32'h55);
    idle_in(); rd_en = 1'b1; read_add = AW'(7);
    cycle();
    chk("rdw_after_b0", 32'(read_data0), 32'h123);
    idle_in();

    // Out-of-range accesses
    wr_en = 1'b1; wr_add = AW'(100); wr_data = 25'h1FFFFFF;
    cycle();
    chk("oob_wr_err", 32'(addr_err1), 32'h1);
    idle_in(); rd_en = 1'b1; read_add = AW'(127);
    cycle();
    chk("oob_rd_err", 32'(addr_err1), 32'h1);
    chk("oob_rd_valid", 32'(rd_valid1), 32'h0);
    chk("oob_rd_hold", 32'(read_data1), 32'h123);
    idle_in(); rd_en = 1'b1; read_add = AW'(99);
    cycle();
    chk("oob_mem_unchanged", 32'(read_data1), 32'h0);
    idle_in();

    // Fill 0..3, clear with same-cycle access, traffic dropped during the sweep
    for (int a = 0; a < 4; a++) begin
      wr_en = 1'b1; wr_add = AW'(a); wr_data = DW'($urandom() | 1);
      cycle();
    end
    idle_in();
    clr_req = 1'b1; wr_en = 1'b1; wr_add = AW'(10); wr_data = 25'h77;
    rd_en = 1'b1; read_add = AW'(2);
    cycle();
    chk("clr_same_cycle_valid", 32'(rd_valid1), 32'h1);
    idle_in();
    count_busy(1'b1, n_busy);
    chk("busy_len_clear", 32'(n_busy), 32'(D));
    for (int a = 0; a < 4; a++) begin
      rd_en = 1'b1; read_add = AW'(a);
      cycle();
      chk("cleared_entry", 32'(read_data1), 32'h0);
    end
    idle_in();

    // Randomized traffic, including collisions, clears and occasional reset
    for (int i = 0; i < 600; i++) begin
      rst_n    = ($urandom_range(0, 199) != 0);
      clr_req  = ($urandom_range(0, 79) == 0);
      wr_en    = 1'($urandom_range(0, 1));
      rd_en    = 1'($urandom_range(0, 1));
      wr_add   = AW'($urandom_range(0, 127));
      read_add = ($urandom_range(0, 3) == 0) ? wr_add : AW'($urandom_range(0, 127));
      wr_data  = DW'($urandom());
      cycle();
    end
    rst_n = 1'b1;
    idle_in();
    for (int i = 0; i < 3 * D && busy1; i++) cycle();
    wr_en = 1'b1; wr_add = AW'(20); wr_data = 25'h0ABCDE;
    cycle();
    idle_in(); rd_en = 1'b1; read_add = AW'(20);
    cycle();
    idle_in();

    // Reset mid-sweep restarts the sweep
    clr_req = 1'b1;
    cycle();
    idle_in();
    repeat (50) cycle();
    rst_n = 1'b0;
    cycle();
    chk("midrst_read_data", 32'(read_data1), 32'h0);
    chk("midrst_busy", 32'(busy1), 32'h1);
    rst_n = 1'b1;
    count_busy(1'b0, n_busy);
    chk("busy_len_midrst", 32'(n_busy), 32'(D));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
